// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with valid/ready handshake and a one-entry result hold.
// Define FAST_SHIFT_EN for single-cycle barrel shifts; the default build shifts one bit per cycle.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alucontrol,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_result,
  output logic        zero
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        accept;
  logic        start_shift;
  logic        shift_last;
  logic [31:0] shift_next;

  // Single-cycle result; in the iterative build shifts only reach here with a zero amount.
  function automatic logic [31:0] alu_op(input logic [3:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
`ifdef FAST_SHIFT_EN
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready   = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
  assign out_valid  = (state_q == FULL);
  assign accept     = in_valid && in_ready && !flush;
  assign alu_result = result_q;
  assign zero       = (result_q == '0);

`ifdef FAST_SHIFT_EN
  assign start_shift = 1'b0;
  assign shift_last  = 1'b0;
  assign shift_next  = result_q;
`else
  logic [4:0] cnt_q, cnt_d;
  logic       dir_right_q, dir_right_d;
  logic       arith_q, arith_d;
  logic       is_shift;

  assign is_shift    = (alucontrol == OP_SLL) || (alucontrol == OP_SRL) || (alucontrol == OP_SRA);
  assign start_shift = is_shift && (operand_b[4:0] != 5'd0);
  assign shift_last  = (cnt_q == 5'd1);
  // result_q doubles as the shift register while the stage is busy shifting.
  assign shift_next  = dir_right_q ? {arith_q & result_q[31], result_q[31:1]}
                                   : {result_q[30:0], 1'b0};

  always_comb begin
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    arith_d     = arith_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && start_shift) begin
      cnt_d       = operand_b[4:0];
      dir_right_d = (alucontrol != OP_SLL);
      arith_d     = (alucontrol == OP_SRA);
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      arith_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      arith_q     <= arith_d;
    end
  end
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    result_d = result_q;
    if (flush) begin
      state_d  = EMPTY;
      result_d = '0;
    end else if (accept) begin
      if (start_shift) begin
        state_d  = SHIFT;
        result_d = operand_a;
      end else begin
        state_d  = FULL;
        result_d = alu_op(alucontrol, operand_a, operand_b);
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end else if (state_q == SHIFT) begin
      result_d = shift_next;
      if (shift_last) state_d = FULL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops against an arithmetic model.
// Build with +define+FAST_SHIFT_EN to check the single-cycle shift variant.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alucontrol = 4'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_result;
  logic        zero;

  int n_vec  = 0;
  int n_miss = 0;

  alu_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference semantics computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p2;
    int n;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    p2 = longint'(1) << n;
    case (op)
      4'd0: model = 32'(ua + ub);
      4'd1: model = 32'(ua - ub);
      4'd2: model = (sa < sb) ? 32'd1 : 32'd0;
      4'd3: model = (ua < ub) ? 32'd1 : 32'd0;
      4'd4: model = a ^ b;
      4'd5: model = a | b;
      4'd6: model = a & b;
      4'd7: model = 32'(ua * p2);
      4'd8: model = 32'(ua / p2);
      4'd9: model = (sa >= 0) ? 32'(sa / p2) : 32'(-((-sa + p2 - 1) / p2));
      default: model = 32'd0;
    endcase
  endfunction

  // Extra edges after the accept edge before out_valid rises.
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
    model_lat = 0;
`else
    model_lat = (op >= 4'd7 && op <= 4'd9) ? int'(b[4:0]) : 0;
`endif
  endfunction

  // Issue one op from EMPTY, check latency/result/zero, hold it for 'hold' cycles, then pop.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat, exp_lat;
    exp     = model(op, a, b);
    exp_lat = model_lat(op, b);
    in_valid = 1'b1; alucontrol = op; operand_a = a; operand_b = b;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL op_in_ready: op=%0d got %b want 1", op, in_ready); end
    step;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin step; lat++; end
    n_vec++;
    if (lat != exp_lat) begin n_miss++; $display("FAIL op_latency: op=%0d a=%h b=%h got %0d want %0d", op, a, b, lat, exp_lat); end
    n_vec++;
    if (alu_result !== exp) begin n_miss++; $display("FAIL op_result: op=%0d a=%h b=%h got %h want %h", op, a, b, alu_result, exp); end
    n_vec++;
    if (zero !== (exp == 32'd0)) begin n_miss++; $display("FAIL op_zero: op=%0d got %b want %b", op, zero, exp == 32'd0); end
    for (int i = 0; i < hold; i++) begin
      step;
      n_vec++;
      if (out_valid !== 1'b1 || alu_result !== exp) begin
        n_miss++; $display("FAIL op_hold: valid=%b result=%h want 1/%h", out_valid, alu_result, exp);
      end
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL op_pop: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    n_vec++;
    if ({out_valid, in_ready, zero} !== 3'b011 || alu_result !== 32'd0) begin
      n_miss++; $display("FAIL reset_state: valid/ready/zero=%b%b%b result=%h want 011/00000000",
                         out_valid, in_ready, zero, alu_result);
    end
  endtask

  task automatic test_add_overflow;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    in_valid = 1'b1; alucontrol = 4'd1; operand_a = 32'd5; operand_b = 32'd5;
    step;
    n_vec++;
    if (out_valid !== 1'b1 || alu_result !== 32'd0 || zero !== 1'b1) begin
      n_miss++; $display("FAIL stream_sub: valid=%b result=%h zero=%b want 1/0/1", out_valid, alu_result, zero);
    end
    alucontrol = 4'd2; operand_a = 32'hFFFF_FFFF; operand_b = 32'h1;
    step;
    n_vec++;
    if (out_valid !== 1'b1 || alu_result !== 32'd1 || zero !== 1'b0) begin
      n_miss++; $display("FAIL stream_slt: valid=%b result=%h zero=%b want 1/1/0", out_valid, alu_result, zero);
    end
    alucontrol = 4'd3;
    step;
    n_vec++;
    if (out_valid !== 1'b1 || alu_result !== 32'd0 || zero !== 1'b1) begin
      n_miss++; $display("FAIL stream_sltu: valid=%b result=%h zero=%b want 1/0/1", out_valid, alu_result, zero);
    end
    in_valid = 1'b0;
    step;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL stream_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_shift;
    int lat, lows, exp_lat;
    exp_lat = model_lat(4'd9, 32'd4);
    in_valid = 1'b1; alucontrol = 4'd9; operand_a = 32'h8000_0000; operand_b = 32'd4;
    step;
    in_valid = 1'b0;
    lat = 0; lows = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (in_ready === 1'b0) lows++;
      step; lat++;
    end
    n_vec++;
    if (lat != exp_lat) begin n_miss++; $display("FAIL sra_latency: got %0d want %0d", lat, exp_lat); end
    n_vec++;
    if (lows != exp_lat) begin n_miss++; $display("FAIL sra_busy: in_ready low %0d cycles want %0d", lows, exp_lat); end
    n_vec++;
    if (alu_result !== 32'hF800_0000) begin n_miss++; $display("FAIL sra_result: got %h want f8000000", alu_result); end
    out_ready = 1'b1; step; out_ready = 1'b0;
    run_op(4'd8, 32'h8000_0000, 32'd31, 0);
    run_op(4'd9, 32'h8000_0000, 32'd31, 0);
    run_op(4'd9, 32'h7FFF_FFFF, 32'd31, 0);
    run_op(4'd7, 32'h1, 32'hFFFF_FFE0, 0);
    run_op(4'd7, 32'hDEAD_BEEF, 32'd1, 1);
  endtask

  task automatic test_hold;
    in_valid = 1'b1; alucontrol = 4'd5; operand_a = 32'h1234_0000; operand_b = 32'h0000_5678;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || alu_result !== 32'h1234_5678 || in_ready !== 1'b0) begin
        n_miss++; $display("FAIL hold_stable: cycle %0d valid=%b result=%h ready=%b want 1/12345678/0",
                           i, out_valid, alu_result, in_ready);
      end
      step;
    end
    out_ready = 1'b1;
    in_valid = 1'b1; alucontrol = 4'd4; operand_a = 32'h1234_5678; operand_b = 32'hFFFF_0000;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL hold_pop_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || alu_result !== 32'hEDCB_5678) begin
      n_miss++; $display("FAIL hold_pop_push: valid=%b result=%h want 1/edcb5678", out_valid, alu_result);
    end
    out_ready = 1'b1; step; out_ready = 1'b0;
  endtask

  task automatic test_flush;
    in_valid = 1'b1; alucontrol = 4'd7; operand_a = 32'h1; operand_b = 32'd31;
    step;
    in_valid = 1'b0;
    repeat (2) step;
    flush = 1'b1;
    in_valid = 1'b1; alucontrol = 4'd0; operand_a = 32'd3; operand_b = 32'd4;
    step;
    n_vec++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || in_ready !== 1'b1 || zero !== 1'b1) begin
      n_miss++; $display("FAIL flush_shift: valid=%b result=%h ready=%b zero=%b want 0/0/1/1",
                         out_valid, alu_result, in_ready, zero);
    end
    step;
    flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_drop: out_valid got %b want 0", out_valid); end
    run_op(4'd0, 32'd3, 32'd4, 0);
  endtask

  task automatic test_reset_mid_shift;
    in_valid = 1'b1; alucontrol = 4'd9; operand_a = 32'hA5A5_0000; operand_b = 32'd20;
    step;
    in_valid = 1'b0;
    repeat (2) step;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'd0) begin
      n_miss++; $display("FAIL reset_mid_shift: valid=%b ready=%b result=%h want 0/1/0", out_valid, in_ready, alu_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step;
    run_op(4'd1, 32'd0, 32'd1, 0);
  endtask

  task automatic test_illegal;
    for (int op = 10; op < 16; op++) run_op(4'(op), $urandom, $urandom, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      if (($urandom & 3) == 0) b = a;
      if (($urandom & 3) == 0) b[4:0] = 5'd0;
      run_op(4'($urandom_range(0, 15)), a, b, int'($urandom_range(0, 2)));
    end
    run_op(4'd2, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op(4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 0);
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_stream;
    test_shift;
    test_hold;
    test_flush;
    test_reset_mid_shift;
    test_illegal;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
